// File: rtl/freq_sel_ctrl_pkg.sv
// Shared definitions for the frequency-select path: code width, code limits and
// the request FSM encoding used by the clock manager and display logic.
package freq_sel_ctrl_pkg;

  localparam int PROG_W = 3;
  localparam logic [PROG_W-1:0] PROG_MIN = 3'd0;
  localparam logic [PROG_W-1:0] PROG_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/freq_sel_ctrl_btn_debounce.sv
// One button input path: 2-FF synchronizer, counter debouncer and a registered
// rising-edge pulse on the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync0;
  logic             sync1;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync0   <= raw;
      sync1   <= sync0;
      level_q <= level;
      press   <= level & ~level_q;
      // The level only follows the synced input after it has disagreed for
      // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
      if (sync1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/freq_sel_ctrl.sv
// Button front-end for the clock manager: keeps the selected code, issues it with
// a one-cycle update pulse and waits for prog_fb to confirm it.
module freq_sel_ctrl
  import freq_sel_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ACK_TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_load,
  input  logic [PROG_W-1:0] sw_prog,
  input  logic [PROG_W-1:0] prog_fb,
  output logic              update,
  output logic [PROG_W-1:0] prog_in,
  output logic              busy,
  output logic              err,
  output fsm_state_t        fsm_state
);

  localparam int TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic               up_p;
  logic               down_p;
  logic               load_p;
  logic               any_press;
  logic [PROG_W-1:0]  sel;
  logic [TIMER_W-1:0] timer;
  fsm_state_t         state;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .raw(btn_up), .press(up_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .raw(btn_down), .press(down_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk(clk), .rst(rst), .raw(btn_load), .press(load_p)
  );

  assign any_press = up_p | down_p | load_p;
  assign fsm_state = state;

  // Load beats up/down; up and down together cancel; steps saturate at the ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= PROG_MIN;
    end else if (load_p) begin
      sel <= sw_prog;
    end else if (up_p && !down_p && sel != PROG_MAX) begin
      sel <= sel + PROG_W'(1);
    end else if (down_p && !up_p && sel != PROG_MIN) begin
      sel <= sel - PROG_W'(1);
    end
  end

  // Handshake with the clock manager: update is high for exactly one cycle
  // (the ISSUE state) with prog_in already valid; prog_in then holds until the
  // FSM is back in IDLE, and the request is complete when prog_fb equals prog_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      update  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      prog_in <= PROG_MIN;
      timer   <= '0;
    end else begin
      update <= 1'b0;
      case (state)
        IDLE: begin
          if (sel != prog_fb) begin
            state   <= ISSUE;
            update  <= 1'b1;
            busy    <= 1'b1;
            prog_in <= sel;
          end
        end
        ISSUE: begin
          state <= WAIT_ACK;
          timer <= '0;
        end
        WAIT_ACK: begin
          if (prog_fb == prog_in) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timer == TIMER_W'(ACK_TIMEOUT - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (any_press) err <= 1'b0;
    end
  end

endmodule
